// File: rtl/rr_mux_arbiter.sv
// Registered N:1 multiplexer with per-channel valid/ready.
// Selection is round-robin (MODE 0) or by explicit channel address (MODE 1).
module rr_mux_arbiter #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned MODE     = 0,
   parameter int unsigned SELW     = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
   input  logic [SELW-1:0]           sel,
   output logic [WIDTH-1:0]          out_data,
   output logic [SELW-1:0]           out_chan,
   output logic                      out_valid,
   input  logic                      out_ready
);

   logic [WIDTH-1:0]    r_out_data;
   logic [SELW-1:0]     r_out_chan;
   logic                r_out_valid;
   logic [SELW-1:0]     r_last;

   logic                w_load_en;
   logic [CHANNELS-1:0] w_grant;
   logic [SELW-1:0]     w_gidx;
   logic                w_any;
   logic [SELW-1:0]     w_cand;
   logic [WIDTH-1:0]    w_data;

   assign w_load_en = !r_out_valid || out_ready;

   always_comb begin
      w_grant = '0;
      w_gidx  = '0;
      w_any   = 1'b0;
      w_cand  = '0;
      if (MODE == 0) begin
         // Search starts one past the last granted channel and wraps modulo CHANNELS.
         for (int unsigned k = 1; k <= CHANNELS; k++) begin
            w_cand = SELW'((32'(r_last) + k) % CHANNELS);
            if (!w_any && in_valid[w_cand]) begin
               w_grant[w_cand] = 1'b1;
               w_gidx          = w_cand;
               w_any           = 1'b1;
            end
         end
      end else begin
         if (32'(sel) < CHANNELS) begin
            if (in_valid[sel]) begin
               w_grant[sel] = 1'b1;
               w_gidx       = sel;
               w_any        = 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_data = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         if (w_grant[i]) w_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   assign in_ready = (w_load_en && !reset) ? w_grant : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_data  <= '0;
         r_out_chan  <= '0;
         r_out_valid <= 1'b0;
         r_last      <= SELW'(CHANNELS - 1);
      end else if (w_load_en) begin
         if (w_any) begin
            r_out_data  <= w_data;
            r_out_chan  <= w_gidx;
            r_out_valid <= 1'b1;
            if (MODE == 0) r_last <= w_gidx;
         end else begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign out_data  = r_out_data;
   assign out_chan  = r_out_chan;
   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: a round-robin instance and an address-mode instance
// share inputs; each task checks one scenario against hand-computed values.
module tb_rr_mux_arbiter;

   localparam int unsigned W  = 32;
   localparam int unsigned CH = 4;
   localparam int unsigned SW = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic [CH*W-1:0]   in_data;
   logic [CH-1:0]     in_valid;
   logic              out_ready;
   logic [SW-1:0]     sel0;
   logic [SW-1:0]     sel1;

   logic [CH-1:0]     in_ready0, in_ready1;
   logic [W-1:0]      out_data0, out_data1;
   logic [SW-1:0]     out_chan0, out_chan1;
   logic              out_valid0, out_valid1;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   rr_mux_arbiter #(.WIDTH(W), .CHANNELS(CH), .MODE(0)) dut0 (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready0), .sel(sel0), .out_data(out_data0),
      .out_chan(out_chan0), .out_valid(out_valid0), .out_ready(out_ready)
   );

   rr_mux_arbiter #(.WIDTH(W), .CHANNELS(CH), .MODE(1)) dut1 (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready1), .sel(sel1), .out_data(out_data1),
      .out_chan(out_chan1), .out_valid(out_valid1), .out_ready(out_ready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_default_data();
      for (int i = 0; i < CH; i++) in_data[i*W +: W] = 32'hA0 + i;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      in_valid  = '0;
      out_ready = 1'b1;
      sel1      = '0;
      set_default_data();
      tick();
      tick();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      in_valid = 4'hF;
      tick();
      vectors++;
      if (out_valid0 !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_preload out_valid got %b want 1", out_valid0);
      end
      #2;
      reset = 1'b1;
      #1;
      vectors++;
      if (out_valid0 !== 1'b0 || out_data0 !== 32'h0 || out_chan0 !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_async got valid=%b data=%h chan=%0d want 0/0/0",
                  out_valid0, out_data0, out_chan0);
      end
      vectors++;
      if (in_ready0 !== 4'b0000 || in_ready1 !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_in_ready got %b/%b want 0000/0000", in_ready0, in_ready1);
      end
      tick();
      reset = 1'b0;
      #1;
      vectors++;
      if (in_ready0 !== 4'b0001) begin
         miscompares++;
         $display("FAIL reset_first_grant in_ready got %b want 0001", in_ready0);
      end
      tick();
      vectors++;
      if (out_chan0 !== 2'd0 || out_data0 !== 32'hA0 || out_valid0 !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_first_word got chan=%0d data=%h valid=%b want 0/a0/1",
                  out_chan0, out_data0, out_valid0);
      end
   endtask

   task automatic test_round_robin();
      logic [SW-1:0] exp_chan [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      do_reset();
      in_valid = 4'hF;
      for (int k = 0; k < 6; k++) begin
         tick();
         vectors++;
         if (out_valid0 !== 1'b1 || out_chan0 !== exp_chan[k] ||
             out_data0 !== 32'hA0 + 32'(exp_chan[k])) begin
            miscompares++;
            $display("FAIL rr_step%0d got valid=%b chan=%0d data=%h want 1/%0d/%h",
                     k, out_valid0, out_chan0, out_data0, exp_chan[k], 32'hA0 + 32'(exp_chan[k]));
         end
      end
   endtask

   task automatic test_sparse_wrap();
      logic [SW-1:0] exp_chan [6] = '{2'd2, 2'd3, 2'd2, 2'd3, 2'd0, 2'd2};
      do_reset();
      in_valid = 4'b1100;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (k == 3) in_valid = 4'b1101;
         vectors++;
         if (out_valid0 !== 1'b1 || out_chan0 !== exp_chan[k]) begin
            miscompares++;
            $display("FAIL sparse_step%0d got valid=%b chan=%0d want 1/%0d",
                     k, out_valid0, out_chan0, exp_chan[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      in_valid = 4'hF;
      tick();
      tick();
      out_ready = 1'b0;
      #1;
      vectors++;
      if (out_chan0 !== 2'd1 || in_ready0 !== 4'b0000) begin
         miscompares++;
         $display("FAIL bp_enter got chan=%0d in_ready=%b want 1/0000", out_chan0, in_ready0);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         vectors++;
         if (out_valid0 !== 1'b1 || out_chan0 !== 2'd1 || out_data0 !== 32'hA1 ||
             in_ready0 !== 4'b0000) begin
            miscompares++;
            $display("FAIL bp_hold%0d got valid=%b chan=%0d data=%h in_ready=%b want 1/1/a1/0000",
                     k, out_valid0, out_chan0, out_data0, in_ready0);
         end
      end
      out_ready = 1'b1;
      #1;
      vectors++;
      if (in_ready0 !== 4'b0100) begin
         miscompares++;
         $display("FAIL bp_release in_ready got %b want 0100", in_ready0);
      end
      tick();
      vectors++;
      if (out_chan0 !== 2'd2 || out_data0 !== 32'hA2) begin
         miscompares++;
         $display("FAIL bp_next got chan=%0d data=%h want 2/a2", out_chan0, out_data0);
      end
   endtask

   task automatic test_address();
      do_reset();
      sel1     = 2'd2;
      in_valid = 4'hF;
      #1;
      vectors++;
      if (in_ready1 !== 4'b0100) begin
         miscompares++;
         $display("FAIL addr_ready got %b want 0100", in_ready1);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         vectors++;
         if (out_valid1 !== 1'b1 || out_chan1 !== 2'd2 || out_data1 !== 32'hA2 ||
             in_ready1 !== 4'b0100) begin
            miscompares++;
            $display("FAIL addr_word%0d got valid=%b chan=%0d data=%h in_ready=%b want 1/2/a2/0100",
                     k, out_valid1, out_chan1, out_data1, in_ready1);
         end
      end
      sel1     = 2'd3;
      in_valid = 4'b0111;
      #1;
      vectors++;
      if (in_ready1 !== 4'b0000) begin
         miscompares++;
         $display("FAIL addr_nogrant in_ready got %b want 0000", in_ready1);
      end
      tick();
      vectors++;
      if (out_valid1 !== 1'b0 || out_chan1 !== 2'd2 || out_data1 !== 32'hA2) begin
         miscompares++;
         $display("FAIL addr_drop got valid=%b chan=%0d data=%h want 0/2/a2",
                  out_valid1, out_chan1, out_data1);
      end
   endtask

   task automatic test_pass_through();
      do_reset();
      in_valid = 4'b0010;
      for (int k = 0; k < 5; k++) begin
         in_data[1*W +: W] = 32'h100 + k;
         tick();
         vectors++;
         if (out_valid0 !== 1'b1 || out_chan0 !== 2'd1 || out_data0 !== 32'h100 + k) begin
            miscompares++;
            $display("FAIL pass_word%0d got valid=%b chan=%0d data=%h want 1/1/%h",
                     k, out_valid0, out_chan0, out_data0, 32'h100 + k);
         end
      end
      set_default_data();
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = '0;
      out_ready = 1'b1;
      sel0      = '0;
      sel1      = '0;
      set_default_data();
      test_reset();
      test_round_robin();
      test_sparse_wrap();
      test_backpressure();
      test_address();
      test_pass_through();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

endmodule
